flag_reg_stack: RTL
===================

Name: flag_reg_stack

Overview:
Parametrised successor to the 4-bit SZCV flag register. It holds a WIDTH-bit status/flag register with per-bit masked load, plus a DEPTH-entry LIFO save stack. The stack saves flags on interrupt/call entry and restores them on return. It sits beside the ALU and the interrupt/sequencer control, and its registered output feeds the branch-condition logic.

Parameters:
WIDTH, 4, number of flag bits (bit 3..0 = S,Z,C,V at default)
DEPTH, 4, number of save-stack entries (>=1)
RESET_VAL, {WIDTH{1'b0}}, flag register value after reset
CW, $clog2(DEPTH+1), width of depth count (derived, not overridden)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
ld_flag  input  1  load enable for flag register
flag_in  input  WIDTH  new flag values from ALU
flag_mask  input  WIDTH  per-bit load enable; bit i loads only when ld_flag=1 and flag_mask[i]=1
push  input  1  save current flag_out to stack top
pop  input  1  restore flag_out from stack top
err_clr  input  1  clear sticky error flags
flag_out  output  WIDTH  current flag register
depth  output  CW  number of valid stack entries, 0..DEPTH
full  output  1  depth==DEPTH (combinational from depth)
empty  output  1  depth==0 (combinational from depth)
ovf_err  output  1  sticky: push attempted while full
unf_err  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - flag_out=RESET_VAL, depth=0, ovf_err=0, unf_err=0.
  - All stack entries are cleared to 0.
  - Reset mid-operation discards all saved contexts.
- All outputs are registered except full/empty. Effects are visible the cycle after the qualifying edge.
- Stack entries are indexed 0..DEPTH-1. The top entry is index depth-1.
- Per-cycle actions, evaluated on the edge from the sampled inputs:
  - push=1, pop=0, not full: stack[depth] <= flag_out (the pre-edge value); depth <= depth+1.
  - push=1, pop=0, full: stack and depth unchanged; ovf_err <= 1.
  - pop=1, push=0, not empty: flag_out <= stack[depth-1]; depth <= depth-1. ld_flag is ignored this cycle; the restore wins for all bits.
  - pop=1, push=0, empty: flag_out follows the normal ld rule; depth stays 0; unf_err <= 1.
  - push=1 and pop=1: no stack operation, no error. depth is unchanged. flag_out follows the normal ld rule.
  - Normal ld rule: for each bit i, flag_out[i] <= (ld_flag & flag_mask[i]) ? flag_in[i] : flag_out[i].
- Push with ld in the same cycle is legal:
  - The stack saves the old flags.
  - flag_out takes the masked new value.
  - This is the interrupt-entry case.
- Sticky errors:
  - Set by the conditions above.
  - Cleared by err_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - Errors never block further operation.
- The depth count never wraps: it saturates at 0 and at DEPTH, as given by the rules above.
- No X propagation: entries above depth-1 keep stale values but are never driven to flag_out.

Test Plan:
- Reset then hold: assert rst=0 mid-cycle with flag_out=4'hF and depth=2 -> flag_out=4'h0, depth=0, empty=1, errors 0 immediately, without a clock edge.
- Masked load: flag_out=4'b1010, ld_flag=1, flag_in=4'b0101, flag_mask=4'b0011 -> flag_out=4'b1001 next cycle. With ld_flag=0, flag_out is unchanged.
- Push/pop round trip:
  - Load 4'h3, then push+ld with flag_in=4'h0 and mask=4'hF -> flag_out=4'h0, depth=1.
  - Load 4'hC, then pop with ld_flag=1 and flag_in=4'hF -> flag_out=4'h3, depth=0.
- Nesting to full and overflow (DEPTH=4):
  - Push values 1,2,3,4 -> full=1, depth=4.
  - A 5th push -> depth stays 4, ovf_err=1.
  - Four pops -> flag_out sequence 4,3,2,1, then empty=1.
- Underflow: pop while empty with ld_flag=1, flag_in=4'h6, mask=4'hF -> flag_out=4'h6, depth=0, unf_err=1. Then err_clr=1 -> unf_err=0. A pop-while-empty in the same cycle as err_clr -> unf_err stays 1.
- Simultaneous push and pop at depth=2 -> depth stays 2, stack contents unchanged, no error flags, masked ld applied.

Source files
------------

// File: rtl/flag_reg_stack_if.sv
// Control/status bundle between the sequencer/ALU side and flag_reg_stack.
// The master drives the flag and stack controls; the slave returns flags, depth and errors.
interface flag_reg_stack_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic             ld_flag;
  logic [WIDTH-1:0] flag_in;
  logic [WIDTH-1:0] flag_mask;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [WIDTH-1:0] flag_out;
  logic [CW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             ovf_err;
  logic             unf_err;

  modport master (
    output ld_flag, flag_in, flag_mask, push, pop, err_clr,
    input  flag_out, depth, full, empty, ovf_err, unf_err
  );

  modport slave (
    input  ld_flag, flag_in, flag_mask, push, pop, err_clr,
    output flag_out, depth, full, empty, ovf_err, unf_err
  );
endinterface

// File: rtl/flag_reg_stack.sv
// WIDTH-bit flag register with per-bit masked load and a DEPTH-entry LIFO save stack
// used to save/restore flags on interrupt or call entry/return, with sticky misuse errors.
module flag_reg_stack #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic             clk,
  input logic             rst,
  flag_reg_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] flag_r;
  logic [CW-1:0]    depth_r;
  logic [WIDTH-1:0] stack_r [DEPTH];
  logic             ovf_r;
  logic             unf_r;

  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             ovf_set_s;
  logic             unf_set_s;
  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] ld_val_s;
  logic [WIDTH-1:0] flag_nxt_s;

  function automatic logic [WIDTH-1:0] masked_merge(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] new_val,
    input logic [WIDTH-1:0] mask,
    input logic             en
  );
    return en ? ((new_val & mask) | (cur & ~mask)) : cur;
  endfunction

  assign full_s  = (depth_r == CW'(DEPTH));
  assign empty_s = (depth_r == CW'(0));

  // Classify this cycle's stack request; push and pop together cancel out.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    case ({bus.push, bus.pop})
      2'b10: begin
        push_ok_s = ~full_s;
        ovf_set_s = full_s;
      end
      2'b01: begin
        pop_ok_s  = ~empty_s;
        unf_set_s = empty_s;
      end
      default: begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
      end
    endcase
  end

  // Select the top-of-stack entry without indexing past the valid range.
  always_comb begin
    top_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      top_s = (depth_r == CW'(i + 1)) ? stack_r[i] : top_s;
    end
  end

  // Next flag value: a successful restore overrides the masked load on every bit.
  always_comb begin
    ld_val_s = masked_merge(flag_r, bus.flag_in, bus.flag_mask, bus.ld_flag);
    if (pop_ok_s) begin
      flag_nxt_s = top_s;
    end else begin
      flag_nxt_s = ld_val_s;
    end
  end

  // Flag register and sticky error flags; a same-cycle set beats err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_r <= RESET_VAL;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else begin
      flag_r <= flag_nxt_s;
      ovf_r  <= ovf_set_s ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_r);
      unf_r  <= unf_set_s ? 1'b1 : (bus.err_clr ? 1'b0 : unf_r);
    end
  end

  // Save stack and its saturating depth count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_r <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok_s && (depth_r == CW'(i))) begin
          stack_r[i] <= flag_r;
        end
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   depth_r <= depth_r + CW'(1);
        2'b01:   depth_r <= depth_r - CW'(1);
        default: depth_r <= depth_r;
      endcase
    end
  end

  assign bus.flag_out = flag_r;
  assign bus.depth    = depth_r;
  assign bus.full     = full_s;
  assign bus.empty    = empty_s;
  assign bus.ovf_err  = ovf_r;
  assign bus.unf_err  = unf_r;
endmodule
